// File: rtl/boot_pkg.sv
// Shared types and constants for the UART boot loader.
package boot_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN   = 3'd1,
    ST_DATA  = 3'd2,
    ST_WRITE = 3'd3,
    ST_CHECK = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERROR = 3'd6
  } boot_state_e;

  localparam int BYTES_PER_WORD = 4;
  localparam int UART_DATA_BITS = 8;
  localparam int UART_STOP_BITS = 1;

  // Little-endian assembly: each new byte enters at the top and older bytes move down.
  function automatic logic [31:0] le_shift(input logic [31:0] word, input logic [7:0] b);
    return {b, word[31:8]};
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// UART 8N1 receiver: 2-flop synchroniser, mid-bit sampling, start-bit glitch rejection,
// one-cycle byte_valid and frame_err pulses.
module uart_rx_byte
  import boot_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx_i,
  output logic       byte_valid_o,
  output logic [7:0] byte_o,
  output logic       frame_err_o
);

  localparam int              CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]   HALF_M1   = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]   FULL_M1   = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]      LAST_BIT  = 3'(UART_DATA_BITS - 1);
  localparam logic [2:0]      LAST_STOP = 3'(UART_STOP_BITS - 1);

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  rx_state_e     st_q, st_d;
  logic [1:0]    sync_q;
  logic          prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;
  logic          rx_s;

  assign rx_s = sync_q[1];

  // Receiver registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q  <= 2'b00;
      prev_q  <= 1'b0;
      st_q    <= RX_IDLE;
      cnt_q   <= {CW{1'b0}};
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], rx_i};
      prev_q  <= rx_s;
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  // Frame sequencing; the stop bit is only trusted once per stop-bit period.
  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q + CW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    case (st_q)
      RX_IDLE: begin
        cnt_d = {CW{1'b0}};
        bit_d = 3'd0;
        if (prev_q && !rx_s) st_d = RX_START;
        else                 st_d = RX_IDLE;
      end
      RX_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d = {CW{1'b0}};
          if (rx_s) st_d = RX_IDLE;
          else      st_d = RX_DATA;
        end else begin
          st_d = RX_START;
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = {CW{1'b0}};
          shift_d = {rx_s, shift_q[7:1]};
          if (bit_q == LAST_BIT) begin
            bit_d = 3'd0;
            st_d  = RX_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
            st_d  = RX_DATA;
          end
        end else begin
          st_d = RX_DATA;
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d = {CW{1'b0}};
          if (!rx_s) begin
            err_d = 1'b1;
            st_d  = RX_IDLE;
          end else if (bit_q == LAST_STOP) begin
            valid_d = 1'b1;
            st_d    = RX_IDLE;
          end else begin
            bit_d = bit_q + 3'd1;
            st_d  = RX_STOP;
          end
        end else begin
          st_d = RX_STOP;
        end
      end
      default: st_d = RX_IDLE;
    endcase
  end

  assign byte_valid_o = valid_q;
  assign byte_o       = shift_q;
  assign frame_err_o  = err_q;

endmodule

// File: rtl/uart_boot_loader.sv
// Boot loader: receives a length-prefixed image over UART, writes it to instruction memory,
// then releases the core. Optional trailing checksum with `define BOOT_CHECKSUM_EN.
module uart_boot_loader
  import boot_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int IMEM_AW      = 12
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               io_uart_rx,
  input  logic               io_boot_en,
  output logic               io_imem_wr_en,
  output logic [IMEM_AW-1:0] io_imem_addr,
  output logic [31:0]        io_imem_wdata,
  input  logic               io_imem_ready,
  output logic               io_core_reset,
  output logic               io_boot_done,
  output logic               io_boot_error
);

  localparam logic [32:0] IMEM_WORDS = 33'd1 << IMEM_AW;
  localparam logic [1:0]  LAST_BYTE  = 2'(BYTES_PER_WORD - 1);
`ifdef BOOT_CHECKSUM_EN
  localparam boot_state_e AFTER_LOAD = ST_CHECK;
`else
  localparam boot_state_e AFTER_LOAD = ST_DONE;
`endif

  boot_state_e        state_q, state_d;
  logic               rx_valid_s, rx_err_s;
  logic [7:0]         rx_byte_s;
  logic               hold_full_q, hold_full_d;
  logic [7:0]         hold_q, hold_d;
  logic [1:0]         idx_q, idx_d;
  logic [31:0]        shift_q, shift_d, len_q, len_d, wdata_q, wdata_d;
  logic [IMEM_AW-1:0] addr_q, addr_d;
  logic [32:0]        words_q, words_d;
`ifdef BOOT_CHECKSUM_EN
  logic [31:0]        sum_q, sum_d;
`endif
  logic               wr_en_q, wr_en_d, core_rst_q, core_rst_d;
  logic               done_q, done_d, err_q, err_d;
  logic               active_s, take_s, hs_s, last_s, overrun_s;
  logic [31:0]        shifted_s;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clock        (clock),
    .reset        (reset),
    .rx_i         (io_uart_rx),
    .byte_valid_o (rx_valid_s),
    .byte_o       (rx_byte_s),
    .frame_err_o  (rx_err_s)
  );

  assign active_s  = (state_q == ST_LEN) || (state_q == ST_DATA) ||
                     (state_q == ST_WRITE) || (state_q == ST_CHECK);
  assign take_s    = hold_full_q && active_s && (state_q != ST_WRITE);
  assign overrun_s = rx_valid_s && hold_full_q && !take_s;
  assign hs_s      = wr_en_q && io_imem_ready;
  assign last_s    = (words_q + 33'd1) == {1'b0, len_q};
  assign shifted_s = le_shift(shift_q, hold_q);

  // State register, datapath and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      hold_full_q <= 1'b0;
      hold_q      <= 8'd0;
      idx_q       <= 2'd0;
      shift_q     <= 32'd0;
      len_q       <= 32'd0;
      wdata_q     <= 32'd0;
      addr_q      <= {IMEM_AW{1'b0}};
      words_q     <= 33'd0;
`ifdef BOOT_CHECKSUM_EN
      sum_q       <= 32'd0;
`endif
      wr_en_q     <= 1'b0;
      core_rst_q  <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_full_q <= hold_full_d;
      hold_q      <= hold_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      len_q       <= len_d;
      wdata_q     <= wdata_d;
      addr_q      <= addr_d;
      words_q     <= words_d;
`ifdef BOOT_CHECKSUM_EN
      sum_q       <= sum_d;
`endif
      wr_en_q     <= wr_en_d;
      core_rst_q  <= core_rst_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  // Next state, byte assembly and the one-deep holding register.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    len_d   = len_q;
    wdata_d = wdata_q;
    addr_d  = addr_q;
    words_d = words_q;
`ifdef BOOT_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    if (rx_valid_s && active_s) begin
      hold_full_d = 1'b1;
      hold_d      = rx_byte_s;
    end else if (take_s) begin
      hold_full_d = 1'b0;
    end else begin
      hold_full_d = hold_full_q;
    end
    case (state_q)
      ST_IDLE: begin
        if (io_boot_en) state_d = ST_LEN;
        else            state_d = ST_DONE;
      end
      ST_LEN: begin
        if (take_s) begin
          idx_d   = idx_q + 2'd1;
          shift_d = shifted_s;
          if (idx_q == LAST_BYTE) begin
            len_d = shifted_s;
            if (shifted_s == 32'd0)                    state_d = AFTER_LOAD;
            else if ({1'b0, shifted_s} > IMEM_WORDS)   state_d = ST_ERROR;
            else                                       state_d = ST_DATA;
          end else begin
            state_d = ST_LEN;
          end
        end else begin
          state_d = ST_LEN;
        end
      end
      ST_DATA: begin
        if (take_s) begin
          idx_d   = idx_q + 2'd1;
          wdata_d = le_shift(wdata_q, hold_q);
          if (idx_q == LAST_BYTE) state_d = ST_WRITE;
          else                    state_d = ST_DATA;
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_WRITE: begin
        if (hs_s) begin
          words_d = words_q + 33'd1;
`ifdef BOOT_CHECKSUM_EN
          sum_d   = sum_q + wdata_q;
`endif
          // The final word leaves addr in place so it never passes the top of memory.
          if (last_s) begin
            state_d = AFTER_LOAD;
          end else begin
            addr_d  = addr_q + IMEM_AW'(1);
            state_d = ST_DATA;
          end
        end else begin
          state_d = ST_WRITE;
        end
      end
      ST_CHECK: begin
`ifdef BOOT_CHECKSUM_EN
        if (take_s) begin
          idx_d   = idx_q + 2'd1;
          shift_d = shifted_s;
          if (idx_q == LAST_BYTE) state_d = (shifted_s == sum_q) ? ST_DONE : ST_ERROR;
          else                    state_d = ST_CHECK;
        end else begin
          state_d = ST_CHECK;
        end
`else
        state_d = ST_ERROR;
`endif
      end
      ST_DONE:  state_d = ST_DONE;
      ST_ERROR: state_d = ST_ERROR;
      default:  state_d = ST_ERROR;
    endcase
    state_d = (active_s && (rx_err_s || overrun_s)) ? ST_ERROR : state_d;
  end

  // Output decode from the next state so outputs register alongside the state.
  always_comb begin
    wr_en_d    = (state_d == ST_WRITE);
    core_rst_d = (state_d != ST_DONE);
    done_d     = (state_d == ST_DONE);
    err_d      = (state_d == ST_ERROR);
  end

  assign io_imem_wr_en = wr_en_q;
  assign io_imem_addr  = addr_q;
  assign io_imem_wdata = wdata_q;
  assign io_core_reset = core_rst_q;
  assign io_boot_done  = done_q;
  assign io_boot_error = err_q;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Self-checking bench for uart_boot_loader; expected memory writes are queued as bytes are sent.
module tb_uart_boot_loader;

  localparam int CPB = 16;
  localparam int AW  = 4;

  logic          clk = 1'b0;
  logic          rst_n, rx, boot_en, ready;
  logic          wr_en, core_rst, done, err;
  logic [AW-1:0] addr;
  logic [31:0]   wdata;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [31:0]   d;
  } wr_t;

  wr_t           exp_q[$];
  wr_t           popped;
  logic [31:0]   exp_sum;
  logic [AW-1:0] last_addr;
  int            total = 0;
  int            bad = 0;
  int            wr_count = 0;
  int            cycle = 0;
  int            hs_cycle = -1;

  always #5 clk = ~clk;

  uart_boot_loader #(.CLKS_PER_BIT(CPB), .IMEM_AW(AW)) dut (
    .clock         (clk),
    .reset         (rst_n),
    .io_uart_rx    (rx),
    .io_boot_en    (boot_en),
    .io_imem_wr_en (wr_en),
    .io_imem_addr  (addr),
    .io_imem_wdata (wdata),
    .io_imem_ready (ready),
    .io_core_reset (core_rst),
    .io_boot_done  (done),
    .io_boot_error (err)
  );

  always @(posedge clk) cycle <= cycle + 1;

  // While wr_en is up, addr/wdata must match the oldest queued write; pop on handshake.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && wr_en === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write addr=%0d data=%h", addr, wdata);
      end else if (addr !== exp_q[0].a || wdata !== exp_q[0].d) begin
        bad++;
        $display("FAIL write_content got addr=%0d data=%h want addr=%0d data=%h",
                 addr, wdata, exp_q[0].a, exp_q[0].d);
      end
      if (ready) begin
        wr_count++;
        hs_cycle  = cycle;
        last_addr = addr;
        if (exp_q.size() > 0) popped = exp_q.pop_front();
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b1;
    repeat (CPB) tick();
    rx = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) tick();
    end
    rx = stop;
    repeat (CPB) tick();
    rx = 1'b1;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
  endtask

  task automatic load_word(input logic [AW-1:0] a, input logic [31:0] w);
    wr_t e;
    e.a = a;
    e.d = w;
    exp_q.push_back(e);
    exp_sum = exp_sum + w;
    send_word(w);
  endtask

  task automatic send_trailer();
`ifdef BOOT_CHECKSUM_EN
    send_word(exp_sum);
`endif
  endtask

  task automatic do_reset(input logic en);
    rst_n = 1'b0;
    rx = 1'b1;
    ready = 1'b1;
    boot_en = en;
    exp_q.delete();
    exp_sum = 32'd0;
    wr_count = 0;
    hs_cycle = -1;
    repeat (3) tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_end(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget && at < 0; i++) begin
      @(negedge clk);
      if (done === 1'b1 || err === 1'b1) at = cycle;
    end
    total++;
    if (at < 0) begin
      bad++;
      $display("FAIL end_timeout budget=%0d", budget);
    end
  endtask

  task automatic wait_wr(input int budget);
    int n = 0;
    while (wr_en !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (wr_en !== 1'b1) begin
      bad++;
      $display("FAIL wr_en_timeout waited=%0d", n);
    end
  endtask

  task automatic check_end(input string name, input logic exp_done, input int exp_writes);
    total++;
    if ({done, err, core_rst} !== {exp_done, ~exp_done, ~exp_done}) begin
      bad++;
      $display("FAIL %s_status got done=%b err=%b core_rst=%b want done=%b", name, done, err,
               core_rst, exp_done);
    end
    total++;
    if (wr_count != exp_writes || exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_writes got %0d (pending %0d) want %0d", name, wr_count, exp_q.size(),
               exp_writes);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rx = 1'b1; boot_en = 1'b1; ready = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    total++;
    if ({wr_en, core_rst, done, err} !== 4'b0100) begin
      bad++;
      $display("FAIL reset_ctrl got %b want 0100", {wr_en, core_rst, done, err});
    end
    total++;
    if ({addr, wdata} !== 36'd0) begin
      bad++;
      $display("FAIL reset_data got addr=%0d data=%h want 0/0", addr, wdata);
    end
  endtask

  task automatic test_skip();
    do_reset(1'b0);
    tick();
    tick();
    @(negedge clk);
    check_end("skip_early", 1'b1, 0);
    repeat (200) tick();
    check_end("skip_late", 1'b1, 0);
  endtask

  task automatic test_normal();
    int at;
    do_reset(1'b1);
    fork
      begin
        send_word(32'd2);
        load_word(4'd0, 32'h0000_0013);
        load_word(4'd1, 32'hDEAD_BEEF);
        send_trailer();
      end
      wait_end(5000, at);
    join
    check_end("normal", 1'b1, 2);
`ifndef BOOT_CHECKSUM_EN
    total++;
    if (at - hs_cycle != 1) begin
      bad++;
      $display("FAIL release_latency got %0d want 1", at - hs_cycle);
    end
`endif
  endtask

  task automatic test_back_pressure();
    int at;
    do_reset(1'b1);
    ready = 1'b0;
    fork
      begin
        send_word(32'd2);
        load_word(4'd0, 32'h0000_0013);
        load_word(4'd1, 32'hDEAD_BEEF);
        send_trailer();
      end
      begin
        wait_wr(3000);
        repeat (100) tick();
        ready = 1'b1;
      end
    join
    wait_end(500, at);
    check_end("back_pressure", 1'b1, 2);
  endtask

  task automatic test_framing();
    do_reset(1'b1);
    send_word(32'd2);
    send_byte(8'h13, 1'b0);
    total++;
    if ({err, core_rst} !== 2'b11) begin
      bad++;
      $display("FAIL framing_err got err=%b core_rst=%b want 1/1", err, core_rst);
    end
    for (int i = 0; i < 3; i++) send_byte(8'h00, 1'b1);
    send_word(32'hDEAD_BEEF);
    check_end("framing", 1'b0, 0);
  endtask

  task automatic test_overrun();
    do_reset(1'b1);
    ready = 1'b0;
    send_word(32'd2);
    load_word(4'd0, 32'h0000_0013);
    send_byte(8'hEF, 1'b1);
    total++;
    if (err !== 1'b0) begin
      bad++;
      $display("FAIL overrun_one_held got err=%b want 0", err);
    end
    send_byte(8'hBE, 1'b1);
    exp_q.delete();
    ready = 1'b1;
    repeat (20) tick();
    check_end("overrun", 1'b0, 0);
  endtask

  task automatic test_length();
    int at;
    do_reset(1'b1);
    send_word(32'd17);
    send_word(32'h1234_5678);
    check_end("len17", 1'b0, 0);

    do_reset(1'b1);
    send_word(32'd0);
    send_trailer();
    wait_end(500, at);
    check_end("len0", 1'b1, 0);

    do_reset(1'b1);
    send_word(32'd16);
    for (int i = 0; i < 16; i++) load_word(AW'(i), 32'h1000_0000 + 32'(i) * 32'h0001_0001);
    send_trailer();
    wait_end(500, at);
    check_end("len16", 1'b1, 16);
    total++;
    if (last_addr !== 4'd15 || addr !== 4'd15) begin
      bad++;
      $display("FAIL len16_addr got last=%0d now=%0d want 15", last_addr, addr);
    end
  endtask

  task automatic test_reset_midload();
    do_reset(1'b1);
    ready = 1'b0;
    send_word(32'd1);
    load_word(4'd0, 32'hCAFE_F00D);
    wait_wr(100);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({wr_en, addr, wdata, core_rst, done, err} !== {1'b0, 4'd0, 32'd0, 3'b100}) begin
      bad++;
      $display("FAIL midload_reset got wr=%b addr=%0d data=%h rst=%b done=%b err=%b",
               wr_en, addr, wdata, core_rst, done, err);
    end
    exp_q.delete();
  endtask

`ifdef BOOT_CHECKSUM_EN
  task automatic test_checksum();
    do_reset(1'b1);
    send_word(32'd2);
    load_word(4'd0, 32'h0000_0013);
    load_word(4'd1, 32'hDEAD_BEEF);
    send_word(32'd0);
    repeat (20) tick();
    check_end("checksum_bad", 1'b0, 2);
  endtask
`endif

  initial begin
    test_reset();
    test_skip();
    test_normal();
    test_back_pressure();
    test_framing();
    test_overrun();
    test_length();
    test_reset_midload();
`ifdef BOOT_CHECKSUM_EN
    test_checksum();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
